// File: rtl/instr_mem_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module   : instr_mem_fetch_if
//  Brief    : Fetch request/response, program-load and status bundle for the
//             synchronous instruction memory.
//  Revision : 1.0 - initial release
// ============================================================================
interface instr_mem_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [1:0]        rsp_fault;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_wdata;
  logic              prog_ready;
  logic              init_done;

  // IF stage / boot loader side
  modport master (
    output req_valid, req_addr, rsp_ready, prog_we, prog_addr, prog_wdata,
    input  req_ready, rsp_valid, rsp_data, rsp_fault, prog_ready, init_done
  );

  // Memory side
  modport slave (
    input  req_valid, req_addr, rsp_ready, prog_we, prog_addr, prog_wdata,
    output req_ready, rsp_valid, rsp_data, rsp_fault, prog_ready, init_done
  );
endinterface
`default_nettype wire

// File: rtl/instr_mem_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instr_mem_fetch
//  Brief    : Synchronous instruction memory with valid/ready fetch port
//             (1-cycle latency, stall hold), fault flagging, program-load
//             write port and a reset-time NOP clear sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_mem_fetch #(
  parameter int                DEPTH          = 1024,
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter logic [DATA_W-1:0] CLEAR_WORD     = 'h00000013,
  parameter bit                CLEAR_ON_RESET = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_mem_fetch_if.slave   bus
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  localparam state_t             c_RESET_STATE = CLEAR_ON_RESET ? S_CLEAR : S_RUN;
  localparam logic [IDX_W-1:0]   c_LAST_IDX    = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W-3:0]  c_DEPTH_WORDS = (ADDR_W-2)'(DEPTH);
  localparam logic [1:0]         c_FAULT_OK    = 2'b00;
  localparam logic [1:0]         c_FAULT_MIS   = 2'b01;
  localparam logic [1:0]         c_FAULT_OOR   = 2'b10;

  state_t             r_state;
  logic [IDX_W-1:0]   r_cnt;
  logic               r_init_done;
  logic               r_rsp_valid;
  logic [DATA_W-1:0]  r_rsp_data;
  logic [1:0]         r_rsp_fault;
  logic [DATA_W-1:0]  r_mem [DEPTH];

  logic [IDX_W-1:0]   w_req_idx;
  logic [IDX_W-1:0]   w_prog_idx;
  logic               w_req_mis;
  logic               w_req_oor;
  logic               w_prog_oor;
  logic               w_req_ready;
  logic               w_accept;
  logic               w_prog_wr;
  logic               w_clear_wr;
  logic               w_mem_we;
  logic [IDX_W-1:0]   w_mem_widx;
  logic [DATA_W-1:0]  w_mem_wdata;
  logic               w_unused_prog_lsb;

  assign w_req_idx   = bus.req_addr[IDX_W+1:2];
  assign w_prog_idx  = bus.prog_addr[IDX_W+1:2];
  assign w_req_mis   = |bus.req_addr[1:0];
  assign w_req_oor   = bus.req_addr[ADDR_W-1:2] >= c_DEPTH_WORDS;
  assign w_prog_oor  = bus.prog_addr[ADDR_W-1:2] >= c_DEPTH_WORDS;
  // Program byte offset is meaningless for word writes
  assign w_unused_prog_lsb = ^bus.prog_addr[1:0];

  // init_done is only ever set in RUN, so it doubles as the "running" qualifier.
  // A pending program write blocks fetches so the RAM sees one access per cycle.
  assign w_req_ready = r_init_done && !bus.prog_we && (!r_rsp_valid || bus.rsp_ready);
  assign w_accept    = bus.req_valid && w_req_ready;
  assign w_prog_wr   = bus.prog_we && r_init_done && !w_prog_oor;
  assign w_clear_wr  = (r_state == S_CLEAR);

  assign w_mem_we    = w_clear_wr || w_prog_wr;
  assign w_mem_widx  = w_clear_wr ? r_cnt : w_prog_idx;
  assign w_mem_wdata = w_clear_wr ? CLEAR_WORD : bus.prog_wdata;

  // RAM write port: clear sequencer or program loader (never both)
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_widx] <= w_mem_wdata;
    end
  end

  // Control FSM with registered response and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_RESET_STATE;
      r_cnt       <= '0;
      r_init_done <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= CLEAR_WORD;
      r_rsp_fault <= c_FAULT_OK;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_LAST_IDX) begin
            r_state     <= S_RUN;
            r_init_done <= 1'b1;
          end
        end
        S_RUN: begin
          r_init_done <= 1'b1;
          if (w_accept) begin
            r_rsp_valid <= 1'b1;
            if (w_req_mis) begin
              r_rsp_fault <= c_FAULT_MIS;
              r_rsp_data  <= CLEAR_WORD;
            end else if (w_req_oor) begin
              r_rsp_fault <= c_FAULT_OOR;
              r_rsp_data  <= CLEAR_WORD;
            end else begin
              r_rsp_fault <= c_FAULT_OK;
              r_rsp_data  <= r_mem[w_req_idx];
            end
          end else if (r_rsp_valid && bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= c_RESET_STATE;
        end
      endcase
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_data   = r_rsp_data;
  assign bus.rsp_fault  = r_rsp_fault;
  assign bus.prog_ready = r_init_done;
  assign bus.init_done  = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_mem_fetch
//  Brief    : Directed scoreboard bench for instr_mem_fetch (DEPTH=16).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_mem_fetch;

  localparam int  c_LIMIT = 40;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [33:0] exp_q [$];

  instr_mem_fetch_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  instr_mem_fetch #(
    .DEPTH          (16),
    .ADDR_W         (32),
    .DATA_W         (32),
    .CLEAR_WORD     (32'h00000013),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a response retires at the next edge when valid && ready
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got data %h fault %b with empty queue",
                 bus.rsp_data, bus.rsp_fault);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        check("rsp_data", bus.rsp_data, e[31:0]);
        check("rsp_fault", {30'd0, bus.rsp_fault}, {30'd0, e[33:32]});
      end
    end
  end

  task automatic idle();
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Present a fetch, wait (bounded) for acceptance, then confirm 1-cycle latency
  task automatic fetch(input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] f, output int waits);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    exp_q.push_back({f, d});
    waits = 0;
    @(negedge clk);
    while (!bus.req_ready && waits < c_LIMIT) begin
      @(negedge clk);
      waits++;
    end
    @(posedge clk);
    #1;
    check("fetch_accepted", {31'd0, waits < c_LIMIT}, 32'd1);
    check("rsp_latency1", {31'd0, bus.rsp_valid}, 32'd1);
  endtask

  task automatic prog(input logic [31:0] a, input logic [31:0] d);
    bus.prog_we    = 1'b1;
    bus.prog_addr  = a;
    bus.prog_wdata = d;
    @(negedge clk);
    check("prog_ready", {31'd0, bus.prog_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.prog_we = 1'b0;
  endtask

  // Count edges from reset release until init_done rises
  task automatic wait_init(output int cyc);
    cyc = 0;
    while (!bus.init_done && cyc < c_LIMIT) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // Directed stimulus
  initial begin
    int w;
    int cyc;
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.rsp_ready  = 1'b1;
    bus.prog_we    = 1'b0;
    bus.prog_addr  = '0;
    bus.prog_wdata = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_data", bus.rsp_data, 32'h00000013);
    check("rst_rsp_fault", {30'd0, bus.rsp_fault}, 32'd0);
    check("rst_prog_ready", {31'd0, bus.prog_ready}, 32'd0);
    check("rst_init_done", {31'd0, bus.init_done}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    wait_init(cyc);
    check("init_cycles", cyc, 32'd16);

    // Cleared contents, first and last word
    fetch(32'h0, 32'h00000013, 2'b00, w);
    fetch(32'h3C, 32'h00000013, 2'b00, w);
    idle();

    // Program load, plus an out-of-range write that must be dropped
    prog(32'h0, 32'h00A00293);
    prog(32'h4, 32'h00000313);
    prog(32'h8, 32'h00000393);
    prog(32'h40, 32'hDEADBEEF);

    // Back-to-back fetches, one accept per cycle
    fetch(32'h0, 32'h00A00293, 2'b00, w);
    check("b2b_wait0", w, 32'd0);
    fetch(32'h4, 32'h00000313, 2'b00, w);
    check("b2b_wait1", w, 32'd0);
    fetch(32'h8, 32'h00000393, 2'b00, w);
    check("b2b_wait2", w, 32'd0);
    idle();

    // Stall: response held, next request blocked
    fetch(32'h4, 32'h00000313, 2'b00, w);
    bus.rsp_ready = 1'b0;
    bus.req_addr  = 32'h8;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_req_ready", {31'd0, bus.req_ready}, 32'd0);
      check("stall_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("stall_rsp_data", bus.rsp_data, 32'h00000313);
      @(posedge clk);
      #1;
    end
    bus.rsp_ready = 1'b1;
    fetch(32'h8, 32'h00000393, 2'b00, w);
    check("stall_release_wait", w, 32'd0);
    idle();

    // Faults: misaligned, out of range, misaligned wins over out of range
    fetch(32'h6, 32'h00000013, 2'b01, w);
    fetch(32'h40, 32'h00000013, 2'b10, w);
    fetch(32'h42, 32'h00000013, 2'b01, w);
    idle();

    // Arbitration: program write blocks a same-cycle fetch, then RAW returns new data
    bus.prog_we    = 1'b1;
    bus.prog_addr  = 32'h4;
    bus.prog_wdata = 32'hFA000AE3;
    bus.req_valid  = 1'b1;
    bus.req_addr   = 32'h4;
    @(negedge clk);
    check("arb_req_ready", {31'd0, bus.req_ready}, 32'd0);
    @(posedge clk);
    #1;
    bus.prog_we = 1'b0;
    fetch(32'h4, 32'hFA000AE3, 2'b00, w);
    check("arb_next_wait", w, 32'd0);
    idle();

    // Reset mid-stream with a response outstanding
    bus.rsp_ready = 1'b0;
    fetch(32'h8, 32'h00000393, 2'b00, w);
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("midrst_init_done", {31'd0, bus.init_done}, 32'd0);
    check("midrst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    if (exp_q.size() > 0) begin
      void'(exp_q.pop_back());
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    wait_init(cyc);
    check("reinit_cycles", cyc, 32'd16);
    fetch(32'h0, 32'h00000013, 2'b00, w);
    fetch(32'h4, 32'h00000013, 2'b00, w);
    fetch(32'h8, 32'h00000013, 2'b00, w);
    idle();
    idle();

    check("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_mem_fetch.md
Name: instr_mem_fetch

Overview:
Parametrised, synchronous successor of the combinational instruction memory. It serves the IF stage through a valid/ready request/response handshake with 1-cycle read latency and holds its output while decode stalls. It flags misaligned and out-of-range fetches. A program-load write port lets a boot loader or testbench fill the memory at run time, and a reset-time clear sequencer fills every word with a NOP.

Parameters:
DEPTH, 1024, number of DATA_W-bit words (power of two, >= 4)
ADDR_W, 32, byte-address width of the fetch and program ports
DATA_W, 32, instruction word width
CLEAR_WORD, 32'h00000013, fill value written by the clear sequencer and returned on faults (addi x0,x0,0)
CLEAR_ON_RESET, 1, 1 = run the clear sequence after reset; 0 = go straight to RUN, contents undefined

Ports:
clk  in  1  single clock; all logic is on the rising edge
rst_n  in  1  asynchronous, active-low reset
req_valid  in  1  IF presents a fetch address
req_ready  out  1  fetch accepted this cycle when req_valid && req_ready
req_addr  in  ADDR_W  fetch byte address
rsp_valid  out  1  rsp_data/rsp_fault are valid
rsp_ready  in  1  decode consumes the response (low = stall)
rsp_data  out  DATA_W  fetched instruction
rsp_fault  out  2  00 ok, 01 misaligned, 10 out of range
prog_we  in  1  program-load write strobe
prog_addr  in  ADDR_W  program byte address (word-aligned; bits [1:0] ignored)
prog_wdata  in  DATA_W  program word
prog_ready  out  1  write is performed this cycle when prog_we && prog_ready
init_done  out  1  clear sequence complete, block in RUN

Behaviour:
- IDX_W = clog2(DEPTH). Word index = addr[IDX_W+1:2]. The address is out of range when addr[ADDR_W-1:2] >= DEPTH.
- Reset values (asserted asynchronously): req_ready=0, rsp_valid=0, rsp_data=CLEAR_WORD, rsp_fault=00, prog_ready=0, init_done=0, clear counter=0. State = CLEAR if CLEAR_ON_RESET, else RUN.
- FSM states are CLEAR and RUN.
- CLEAR: each cycle, mem[cnt] <= CLEAR_WORD and cnt++. After writing index DEPTH-1, move to RUN on the next edge. CLEAR lasts exactly DEPTH cycles. req_ready=0, prog_ready=0, init_done=0 throughout.
- RUN: init_done=1 and prog_ready=1.
- RUN, fetch/program arbitration:
  - req_ready = !prog_we && (!rsp_valid || rsp_ready). A program write has priority over a fetch.
  - prog_we && prog_ready: mem[idx(prog_addr)] <= prog_wdata. Out-of-range program writes are dropped silently.
- RUN, fetch accept: on req_valid && req_ready at edge N, the response is registered at edge N:
  - rsp_valid=1 from cycle N+1, i.e. latency 1.
  - rsp_data = mem[idx], or CLEAR_WORD if faulted.
  - rsp_fault = 01 if addr[1:0] != 0 (takes precedence), else 10 if out of range, else 00.
- Stall: while rsp_valid && !rsp_ready, rsp_data and rsp_fault hold, and no new request is accepted.
- Response retire: rsp_valid && rsp_ready with no new accept -> rsp_valid <= 0. Back-to-back accepts give one response per cycle.
- Read-after-write: a fetch accepted in the cycle after a program write to the same word returns the new data. No same-cycle hazard exists because accept is blocked while prog_we=1.
- Reset mid-operation: any in-flight response is discarded, rsp_valid drops immediately, and the clear sequence restarts from index 0.
- Memory is inferable as single-port synchronous RAM: one write or one read per cycle.

Test Plan:
- Reset, DEPTH=16: rst_n low then high -> init_done rises exactly 16 cycles after release. Then fetch 0x0, 0x3C -> rsp_data=0x00000013 for both, fault=00.
- Program 0x0=0x00A00293, 0x4=0x00000313, 0x8=0x00000393, then fetch 0x0,0x4,0x8 back-to-back with rsp_ready=1 -> rsp_valid high 3 consecutive cycles, data in order, each 1 cycle after accept.
- Stall: fetch 0x4, hold rsp_ready=0 for 3 cycles with req_valid=1 at 0x8 -> req_ready=0, rsp_data held at 0x00000313. rsp_ready=1 -> 0x8 accepted that cycle, its data appears next cycle.
- Faults: fetch 0x6 -> fault=01, data=0x00000013. Fetch 0x40 with DEPTH=16 -> fault=10. Fetch 0x42 -> fault=01 (precedence).
- Arbitration: prog_we=1 (0x4 <= 0xFA000AE3) while req_valid=1 for 0x4 -> req_ready=0 that cycle. Next cycle fetch accepted and returns 0xFA000AE3.
- Reset mid-stream: assert rst_n=0 with rsp_valid=1 -> rsp_valid=0 and init_done=0 immediately. After release, CLEAR reruns and previously programmed words read 0x00000013.
